// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes on both sides. Unsigned or two's-complement per transaction.
module seq_shift_add_multiplier #(
  parameter int A_WIDTH = 5,
  parameter int B_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [B_WIDTH-1:0]         in_b,
  input  logic                       in_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] out_m
);

  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [P-1:0]   r_mcand;   // extended multiplicand, pre-shifted to the current bit weight
  logic [B_WIDTH-1:0] r_mplr;  // multiplier, shifted right so bit 0 is the current bit
  logic           r_sgn;
  logic [CW-1:0]  r_cnt;
  logic [P-1:0]   r_acc;
  logic [P-1:0]   r_out_m;

  logic           w_last;
  logic [P-1:0]   w_acc_nxt;

  assign w_last = (r_cnt == CW'(B_WIDTH - 1));

  // Signed MSB of the multiplier carries negative weight, so it subtracts.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplr[0]) begin
      if (r_sgn && w_last) w_acc_nxt = r_acc - r_mcand;
      else                 w_acc_nxt = r_acc + r_mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_sgn   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_out_m <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mcand <= {{B_WIDTH{in_signed & in_a[A_WIDTH-1]}}, in_a};
          r_mplr  <= in_b;
          r_sgn   <= in_signed;
          r_cnt   <= '0;
          r_acc   <= '0;
        end
        S_CALC: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_out_m <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = (r_state == S_DONE);
  assign out_m     = r_out_m;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: directed vector table, multi-cycle corner
// sequences, and randomized transactions against an arithmetic reference model.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // default-width instance (5x3)
  logic       v0 = 0, rdy0, s0 = 0, ov0, or0 = 0;
  logic [4:0] a0 = 0;
  logic [2:0] b0 = 0;
  logic [7:0] m0;

  // swept instance (8x4)
  logic        v1 = 0, rdy1, s1 = 0, ov1, or1 = 0;
  logic [7:0]  a1 = 0;
  logic [3:0]  b1 = 0;
  logic [11:0] m1;

  seq_shift_add_multiplier #(.A_WIDTH(5), .B_WIDTH(3)) u0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
    .in_signed(s0), .out_valid(ov0), .out_ready(or0), .out_m(m0));

  seq_shift_add_multiplier #(.A_WIDTH(8), .B_WIDTH(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
    .in_signed(s1), .out_valid(ov1), .out_ready(or1), .out_m(m1));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Product from plain integer arithmetic, truncated to the product width.
  function automatic logic [11:0] ref_mul(input int aw, input int bw,
                                           input logic [7:0] a, input logic [3:0] b, input bit s);
    longint av, bv, p, mask;
    av = longint'(a) & ((longint'(1) << aw) - 1);
    bv = longint'(b) & ((longint'(1) << bw) - 1);
    if (s && a[aw-1]) av -= (longint'(1) << aw);
    if (s && b[bw-1]) bv -= (longint'(1) << bw);
    p = av * bv;
    mask = (longint'(1) << (aw + bw)) - 1;
    return 12'(p & mask);
  endfunction

  // Full transaction: wait ready, accept, measure latency, stall, handshake.
  task automatic txn(input bit d, input logic [7:0] a, input logic [3:0] b, input bit s,
                     input int stall, output logic [11:0] m, output int lat);
    int n;
    logic [11:0] m_first;
    n = 0;
    while (!(d ? rdy1 : rdy0) && n < 50) begin step(); n++; end
    if (n >= 50) chk("ready_timeout", 12'(n), 12'd0);
    if (d) begin v1 = 1; a1 = a; b1 = b; s1 = s; end
    else begin v0 = 1; a0 = a[4:0]; b0 = b[2:0]; s0 = s; end
    step();
    v0 = 0; v1 = 0;
    lat = 0;
    while (!(d ? ov1 : ov0) && lat < 50) begin step(); lat++; end
    m = d ? m1 : {4'b0, m0};
    m_first = m;
    for (int k = 0; k < stall; k++) begin
      step();
      chk("stall_hold", {(d ? ov1 : ov0), (d ? m1 : {4'b0, m0})}, {1'b1, m_first});
    end
    if (d) or1 = 1; else or0 = 1;
    step();
    or0 = 0; or1 = 0;
    chk("ready_after_out", 12'(d ? rdy1 : rdy0), 12'd1);
  endtask

  typedef struct {
    logic [4:0] a;
    logic [2:0] b;
    bit         s;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[6];
  logic [11:0] m;
  int lat;

  initial begin
    vt[0] = '{5'b11111, 3'b111, 1'b0, 8'hD9};
    vt[1] = '{5'b11111, 3'b111, 1'b1, 8'h01};
    vt[2] = '{5'b10000, 3'b011, 1'b1, 8'hD0};
    vt[3] = '{5'd3,     3'd2,   1'b0, 8'h06};
    vt[4] = '{5'd7,     3'd7,   1'b0, 8'h31};
    vt[5] = '{5'd31,    3'd1,   1'b0, 8'h1F};

    // reset state
    step();
    chk("rst_in_ready", 12'(rdy0), 12'd0);
    chk("rst_out_valid", 12'(ov0), 12'd0);
    chk("rst_out_m", 12'(m0), 12'd0);
    step();
    reset = 0;
    #1;
    chk("post_rst_ready", 12'(rdy0), 12'd1);

    // directed table
    for (int i = 0; i < 6; i++) begin
      txn(0, {3'b0, vt[i].a}, {1'b0, vt[i].b}, vt[i].s, 0, m, lat);
      chk($sformatf("vec%0d_lat", i), 12'(lat), 12'd3);
      chk($sformatf("vec%0d_m", i), m, {4'b0, vt[i].exp});
    end

    // zero product with 10 cycles of back-pressure
    txn(0, 8'd0, 4'd5, 0, 10, m, lat);
    chk("zero_m", m, 12'h000);
    chk("zero_lat", 12'(lat), 12'd3);

    // in_ready stays low while DONE is stalled
    v0 = 1; a0 = 5'd1; b0 = 3'd1; s0 = 0;
    step(); v0 = 0;
    repeat (3) step();
    repeat (4) begin chk("stall_in_ready", 12'(rdy0), 12'd0); step(); end
    or0 = 1; step(); or0 = 0;
    chk("stall_ready_rise", 12'(rdy0), 12'd1);

    // busy rejection: second request held while first computes
    v0 = 1; a0 = 5'd3; b0 = 3'd2; s0 = 0;
    step();
    a0 = 5'd7; b0 = 3'd7;
    lat = 0;
    while (!ov0 && lat < 50) begin
      chk("busy_in_ready", 12'(rdy0), 12'd0);
      step(); lat++;
    end
    chk("busy_first_lat", 12'(lat), 12'd3);
    chk("busy_first_m", 12'(m0), 12'h06);
    or0 = 1; step(); or0 = 0;
    chk("busy_idle_ready", 12'(rdy0), 12'd1);
    step(); v0 = 0;
    lat = 0;
    while (!ov0 && lat < 50) begin step(); lat++; end
    chk("busy_second_lat", 12'(lat), 12'd3);
    chk("busy_second_m", 12'(m0), 12'h31);
    or0 = 1; step(); or0 = 0;

    // reset during the second CALC cycle
    v0 = 1; a0 = 5'd9; b0 = 3'd7; s0 = 0;
    step(); v0 = 0;
    step();
    reset = 1;
    step();
    chk("abort_ready_in_rst", 12'(rdy0), 12'd0);
    reset = 0;
    #1;
    chk("abort_out_valid", 12'(ov0), 12'd0);
    chk("abort_out_m", 12'(m0), 12'd0);
    chk("abort_ready", 12'(rdy0), 12'd1);
    repeat (4) begin step(); chk("abort_no_valid", 12'(ov0), 12'd0); end
    txn(0, 8'd31, 4'd1, 0, 0, m, lat);
    chk("abort_new_m", m, 12'h01F);

    // parameter sweep instance
    txn(1, 8'hFF, 4'hF, 0, 0, m, lat);
    chk("w8_u_m", m, 12'hEF1);
    chk("w8_u_lat", 12'(lat), 12'd4);
    txn(1, 8'h80, 4'h8, 1, 0, m, lat);
    chk("w8_s_m", m, 12'h400);
    chk("w8_s_lat", 12'(lat), 12'd4);

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [3:0] rb;
      bit rs, d;
      int st;
      ra = 8'($urandom); rb = 4'($urandom); rs = 1'($urandom); d = (i % 4 == 3);
      st = $urandom_range(0, 3);
      txn(d, ra, rb, rs, st, m, lat);
      chk($sformatf("rnd%0d_m", i), m,
          d ? ref_mul(8, 4, ra, rb, rs) : ref_mul(5, 3, {3'b0, ra[4:0]}, {1'b0, rb[2:0]}, rs));
      chk($sformatf("rnd%0d_lat", i), 12'(lat), d ? 12'd4 : 12'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
